// File: rtl/adiabatic_pkg.sv
// rtl/adiabatic_pkg.sv - shared interval encoding and level mapping for the power-clock sequencer
package adiabatic_pkg;

    typedef enum logic [1:0] {
        RISE = 2'd0,
        HOLD = 2'd1,
        FALL = 2'd2,
        WAIT = 2'd3
    } pclk_interval_e;

    function automatic int pclk_level(input pclk_interval_e iv, input int cnt, input int steps);
        case (iv)
            RISE:    return cnt + 1;
            HOLD:    return steps;
            FALL:    return steps - 1 - cnt;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/pclk_phase.sv
// rtl/pclk_phase.sv - one power-clock phase: interval-to-level mapping with registered rail outputs
module pclk_phase
    import adiabatic_pkg::*;
#(
    parameter int STEPS = 4,
    parameter int LW    = $clog2(STEPS + 1),
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic [1:0]    q,
    input  logic [CW-1:0] cnt,
    input  logic [1:0]    offset,
    output logic [LW-1:0] lvl,
    output logic          clkpos,
    output logic          clkneg
);

    logic [1:0]    iv;
    logic [LW-1:0] lvl_d, lvl_q;
    logic          clkpos_d, clkpos_q;

    // Driven from next-state so the registered rails line up with the sequencer state
    always_comb begin
        iv       = q + offset;
        lvl_d    = '0;
        if (run) begin
            lvl_d = LW'(pclk_level(pclk_interval_e'(iv), 32'(cnt), STEPS));
        end
        clkpos_d = (lvl_d == LW'(STEPS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q    <= '0;
            clkpos_q <= 1'b0;
        end else begin
            lvl_q    <= lvl_d;
            clkpos_q <= clkpos_d;
        end
    end

    assign lvl    = lvl_q;
    assign clkpos = clkpos_q;
    assign clkneg = ~clkpos_q;

endmodule

// File: rtl/adiabatic_pclk_gen.sv
// rtl/adiabatic_pclk_gen.sv - four-phase adiabatic power-clock sequencer with capture strobe and period count
module adiabatic_pclk_gen
    import adiabatic_pkg::*;
#(
    parameter int STEPS = 4,
    parameter int LW    = $clog2(STEPS + 1),
    parameter int PCW   = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    output logic [LW-1:0]  lvl1,
    output logic [LW-1:0]  lvl2,
    output logic           clkpos1,
    output logic           clkneg1,
    output logic           clkpos2,
    output logic           clkneg2,
    output logic           busy,
    output logic           sample_stb,
    output logic           period_done,
    output logic [PCW-1:0] period_cnt
);

    localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STEPS - 1);

    logic           busy_d, busy_q;
    logic [1:0]     q_d, q_q;
    logic [CW-1:0]  cnt_d, cnt_q;
    logic [PCW-1:0] period_cnt_d, period_cnt_q;
    logic           stb_d, stb_q;
    logic           done_d, done_q;

    always_comb begin
        busy_d = busy_q;
        q_d    = q_q;
        cnt_d  = cnt_q;
        if (!busy_q) begin
            if (en) begin
                busy_d = 1'b1;
                q_d    = 2'd0;
                cnt_d  = '0;
            end
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            q_d   = q_q + 2'd1;
            // en only matters at the period boundary; rails are already at 0 here
            if (q_q == 2'd3 && !en) begin
                busy_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        stb_d        = busy_d && (q_d == 2'd2) && (cnt_d == CNT_LAST);
        done_d       = busy_d && (q_d == 2'd3) && (cnt_d == CNT_LAST);
        period_cnt_d = done_d ? period_cnt_q + PCW'(1) : period_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= 1'b0;
            q_q          <= 2'd0;
            cnt_q        <= '0;
            period_cnt_q <= '0;
            stb_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            q_q          <= q_d;
            cnt_q        <= cnt_d;
            period_cnt_q <= period_cnt_d;
            stb_q        <= stb_d;
            done_q       <= done_d;
        end
    end

    pclk_phase #(.STEPS(STEPS), .LW(LW), .CW(CW)) u_phase1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (busy_d),
        .q      (q_d),
        .cnt    (cnt_d),
        .offset (2'd0),
        .lvl    (lvl1),
        .clkpos (clkpos1),
        .clkneg (clkneg1)
    );

    // Phase 2 lags by one quarter: interval (q+3) mod 4
    pclk_phase #(.STEPS(STEPS), .LW(LW), .CW(CW)) u_phase2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (busy_d),
        .q      (q_d),
        .cnt    (cnt_d),
        .offset (2'd3),
        .lvl    (lvl2),
        .clkpos (clkpos2),
        .clkneg (clkneg2)
    );

    assign busy        = busy_q;
    assign sample_stb  = stb_q;
    assign period_done = done_q;
    assign period_cnt  = period_cnt_q;

endmodule

// File: tb/tb_adiabatic_pclk_gen.sv
// tb/tb_adiabatic_pclk_gen.sv - directed self-checking bench for adiabatic_pclk_gen
module tb_adiabatic_pclk_gen;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [2:0]  lvl1, lvl2, lvl1_b, lvl2_b;
    logic        clkpos1, clkneg1, clkpos2, clkneg2;
    logic        clkpos1_b, clkneg1_b, clkpos2_b, clkneg2_b;
    logic        busy, sample_stb, period_done;
    logic        busy_b, sample_stb_b, period_done_b;
    logic [15:0] period_cnt;
    logic [1:0]  period_cnt_b;

    int checks = 0;
    int errors = 0;

    int exp_l1 [16] = '{1, 2, 3, 4, 4, 4, 4, 4, 3, 2, 1, 0, 0, 0, 0, 0};
    int exp_l2 [16] = '{0, 0, 0, 0, 1, 2, 3, 4, 4, 4, 4, 4, 3, 2, 1, 0};
    int exp_pc2 [5] = '{1, 2, 3, 0, 1};

    adiabatic_pclk_gen #(.STEPS(4), .PCW(16)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .lvl1        (lvl1),
        .lvl2        (lvl2),
        .clkpos1     (clkpos1),
        .clkneg1     (clkneg1),
        .clkpos2     (clkpos2),
        .clkneg2     (clkneg2),
        .busy        (busy),
        .sample_stb  (sample_stb),
        .period_done (period_done),
        .period_cnt  (period_cnt)
    );

    adiabatic_pclk_gen #(.STEPS(4), .PCW(2)) u_dut_pc2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .lvl1        (lvl1_b),
        .lvl2        (lvl2_b),
        .clkpos1     (clkpos1_b),
        .clkneg1     (clkneg1_b),
        .clkpos2     (clkpos2_b),
        .clkneg2     (clkneg2_b),
        .busy        (busy_b),
        .sample_stb  (sample_stb_b),
        .period_done (period_done_b),
        .period_cnt  (period_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_cycle(input string tag, input int i);
        chk({tag, " lvl1"}, 32'(lvl1), exp_l1[i]);
        chk({tag, " lvl2"}, 32'(lvl2), exp_l2[i]);
        chk({tag, " clkpos1"}, 32'(clkpos1), (exp_l1[i] == 4) ? 1 : 0);
        chk({tag, " clkneg1"}, 32'(clkneg1), (exp_l1[i] == 4) ? 0 : 1);
        chk({tag, " clkpos2"}, 32'(clkpos2), (exp_l2[i] == 4) ? 1 : 0);
        chk({tag, " clkneg2"}, 32'(clkneg2), (exp_l2[i] == 4) ? 0 : 1);
        chk({tag, " sample_stb"}, 32'(sample_stb), (i == 11) ? 1 : 0);
        chk({tag, " period_done"}, 32'(period_done), (i == 15) ? 1 : 0);
        chk({tag, " busy"}, 32'(busy), 1);
    endtask

    task automatic restart();
        rst_n = 1'b0;
        en    = 1'b0;
        tick();
        rst_n = 1'b1;
        en    = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Idle with en low: reset values hold
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle lvl1", 32'(lvl1), 0);
            chk("idle lvl2", 32'(lvl2), 0);
            chk("idle clkneg1", 32'(clkneg1), 1);
            chk("idle clkneg2", 32'(clkneg2), 1);
            chk("idle busy", 32'(busy), 0);
            chk("idle sample_stb", 32'(sample_stb), 0);
            chk("idle period_done", 32'(period_done), 0);
            chk("idle period_cnt", 32'(period_cnt), 0);
        end

        // Continuous run, two back-to-back periods
        en = 1'b1;
        tick();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 16; i++) begin
                check_cycle("run", i);
                if (i == 15) chk("run period_cnt", 32'(period_cnt), p + 1);
                tick();
            end
        end
        chk("run seamless lvl1", 32'(lvl1), 1);

        // Drop en mid-period: period completes, then idle
        restart();
        for (int i = 0; i < 16; i++) begin
            if (i == 5) en = 1'b0;
            check_cycle("stop", i);
            tick();
        end
        chk("stop period_cnt", 32'(period_cnt), 1);
        chk("stop busy", 32'(busy), 0);
        chk("stop lvl1", 32'(lvl1), 0);

        // Drop then re-raise en before boundary: no gap
        restart();
        for (int i = 0; i < 16; i++) begin
            if (i == 5) en = 1'b0;
            if (i == 10) en = 1'b1;
            check_cycle("cancel", i);
            tick();
        end
        chk("cancel busy", 32'(busy), 1);
        chk("cancel lvl1", 32'(lvl1), 1);
        chk("cancel period_cnt", 32'(period_cnt), 1);

        // Asynchronous reset during phase-1 HOLD
        restart();
        for (int i = 0; i < 6; i++) tick();
        chk("hold lvl1", 32'(lvl1), 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async lvl1", 32'(lvl1), 0);
        chk("async clkneg1", 32'(clkneg1), 1);
        chk("async clkpos1", 32'(clkpos1), 0);
        chk("async busy", 32'(busy), 0);
        chk("async period_cnt", 32'(period_cnt), 0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            check_cycle("rerun", i);
            tick();
        end

        // Narrow period counter wraps modulo 4
        restart();
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 16; i++) begin
                if (i == 15) begin
                    chk("pc2 period_done", 32'(period_done_b), 1);
                    chk("pc2 period_cnt", 32'(period_cnt_b), exp_pc2[p]);
                end
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adiabatic_pclk_gen.md
# adiabatic_pclk_gen

Digital four-phase power-clock sequencer that drives the `clkpos1/clkneg1/clkpos2/clkneg2` rails consumed by the adiabatic logic cells such as the adder gates. It produces two overlapping trapezoidal power clocks, with phase 2 lagging phase 1 by one quarter period. Each clock is emitted as a stepwise-charging level code for the rail DAC drivers and as a digital rail abstraction for gate-level simulation. It also emits a capture strobe and period bookkeeping so benches can sample gate outputs at the correct point.

## Interface
Parameters:
- `STEPS`, default 4: clock cycles per quarter interval and number of ramp steps; must be ≥2.
- `LW`, default `$clog2(STEPS+1)`: width of the level codes.
- `PCW`, default 16: width of the completed-period counter.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  run request; sampled only while idle or at a period boundary.
- `lvl1`  out  LW  phase-1 positive-rail level code, 0..STEPS.
- `lvl2`  out  LW  phase-2 positive-rail level code, 0..STEPS.
- `clkpos1`  out  1  high iff `lvl1==STEPS`.
- `clkneg1`  out  1  `~clkpos1`.
- `clkpos2`  out  1  high iff `lvl2==STEPS`.
- `clkneg2`  out  1  `~clkpos2`.
- `busy`  out  1  sequencer running.
- `sample_stb`  out  1  one-cycle pulse on the last cycle of the phase-2 HOLD interval.
- `period_done`  out  1  one-cycle pulse on the last cycle of each period.
- `period_cnt`  out  PCW  completed periods; wraps modulo 2^PCW.

All outputs are registered.

## Operation
- State:
  - `busy`
  - quarter index `q` (0..3)
  - in-quarter counter `cnt` (0..STEPS-1)
  - `period_cnt`
- Interval per phase:
  - phase 1 uses interval `q`.
  - phase 2 uses interval `(q+3) mod 4`.
  - Encoding: 0=RISE, 1=HOLD, 2=FALL, 3=WAIT.
- Level per interval:
  - RISE = `cnt+1`
  - HOLD = `STEPS`
  - FALL = `STEPS-1-cnt`
  - WAIT = 0
- Idle (`busy=0`): both levels are 0, `clkpos*=0`, `clkneg*=1`, and no strobes fire.
- Idle with `en=1` at an edge: `busy←1`, `q←0`, `cnt←0`. The next outputs are `lvl1=1` and `lvl2=0`.
- Running: `cnt` increments. When `cnt==STEPS-1`, `cnt←0` and `q←q+1 mod 4`.
- Period boundary (`q==3`, `cnt==STEPS-1`):
  - `period_done=1` and `period_cnt` increments, both on the same edge.
  - If `en=1`, the sequencer continues seamlessly into `q=0`.
  - If `en=0`, it goes to idle. Both levels are already 0 at that point, so there is no glitch.
- `en` is ignored mid-period. Deasserting it only takes effect at the next period boundary, and reasserting it before the boundary cancels the stop.
- `sample_stb=1` when `q==2` and `cnt==STEPS-1`. This is phase-2 HOLD, and `lvl2==STEPS` at that point.
- Invariant: `lvl1` and `lvl2` are never simultaneously in RISE or simultaneously in FALL.

## Timing
- Reset values: `lvl1=lvl2=0`, `clkpos1=clkpos2=0`, `clkneg1=clkneg2=1`, `busy=0`, `sample_stb=0`, `period_done=0`, `period_cnt=0`, `q=0`, `cnt=0`.
- Reset takes effect immediately and asynchronously, including mid-ramp. Rails drop to 0 without completing FALL.
- Start latency: 1 cycle from the edge that samples `en=1` to `lvl1=1`.
- Period length: `4·STEPS` cycles.
- `clkpos1` is high for `STEPS+1` cycles per period: the last RISE cycle plus all HOLD cycles. `clkpos2` has the same shape, delayed by exactly `STEPS` cycles.
- Stop latency: `busy` falls on the edge after the `period_done` cycle. Worst case is `4·STEPS` cycles after `en` deasserts.

## Structure
- Shared package `adiabatic_pkg`:
  - `typedef enum logic [1:0] {RISE, HOLD, FALL, WAIT} pclk_interval_e`
  - a function `pclk_level(interval, cnt, steps)` returning the level code.
- Sub-module `pclk_phase`: combinational interval-to-level mapping plus the registered `lvl`/`clkpos`/`clkneg` outputs. It is instantiated twice, with the phase offset supplied as an input.
- Top-level `adiabatic_pclk_gen` holds `busy`, `q`, `cnt`, `period_cnt` and the strobes.

## Test plan
All scenarios use `STEPS=4`, so a period is 16 cycles.
- Reset release with `en=0` for 20 cycles → all outputs hold their reset values; no strobes.
- `en` held at 1; cycles counted from the first running cycle:
  - `lvl1` = 1,2,3,4, 4,4,4,4, 3,2,1,0, 0,0,0,0.
  - `lvl2` = 0,0,0,0, 1,2,3,4, 4,4,4,4, 3,2,1,0.
  - `clkpos1` is high in cycles 3–7.
  - `sample_stb` fires at cycle 11 and `period_done` at cycle 15; the pattern repeats with no gap.
- Drop `en` at cycle 5 → the period completes unchanged, `period_cnt=1`, and `busy=0` at cycle 16. Re-raising `en` at cycle 10 instead → the sequencer continues with no idle gap.
- Assert `rst_n=0` at cycle 6 (phase-1 HOLD) → `lvl1=0`, `clkneg1=1`, `busy=0` immediately, before the next edge. Restart → the sequence matches the 16-cycle pattern above exactly.
- `PCW=2`, run 5 periods → `period_cnt` reads 1,2,3,0,1.
